main_memory: RTL and testbench

MAIN_MEMORY -- requirements
Module: main_memory

---
 rtl/cache_pkg.sv | 30 +++
 rtl/main_memory_if.sv | 38 +++
 rtl/main_memory_queue.sv | 69 ++++++
 rtl/main_memory.sv | 136 +++++++++++++
 tb/tb_main_memory.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types for the memory subsystem. Holds the operation
//               code, the address/data word types and the request record
//               that travels through the request queue into the engine.
// Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    Op_INVALID = 2'd0,
    Op_READ    = 2'd1,
    Op_WRITE   = 2'd2
  } Op;

  typedef logic [ADDR_WIDTH-1:0] UbitAddr;
  typedef logic [DATA_WIDTH-1:0] UbitData;

  typedef struct packed {
    Op       op;
    UbitAddr addr;
    UbitData data;
  } MemReq;

endpackage
`default_nettype wire

// File: rtl/main_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : MemBus
// Description : Request/response bus between a requester and main_memory.
//               The requester presents one {op, addr, data} per cycle with
//               no backpressure; the memory returns read data with a
//               one-cycle rsp_vld strobe.
// Ports       : req_op, req_addr, req_data  requester -> memory
//               rsp_vld, rsp_data           memory -> requester
// Revision    : 1.0  initial release
// ============================================================================
interface MemBus;
  import cache_pkg::*;

  Op       req_op;
  UbitAddr req_addr;
  UbitData req_data;
  logic    rsp_vld;
  UbitData rsp_data;

  modport master (
    output req_op,
    output req_addr,
    output req_data,
    input  rsp_vld,
    input  rsp_data
  );

  modport slave (
    input  req_op,
    input  req_addr,
    input  req_data,
    output rsp_vld,
    output rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/main_memory_queue.sv
`default_nettype none
// ============================================================================
// Module      : mem_queue
// Description : Synchronous FIFO of MemReq records. A push while full is
//               accepted only when a pop happens in the same cycle, so the
//               freed slot is reused immediately.
// Ports       : clk, rst           clock, synchronous active-high reset
//               i_push, i_push_data enqueue request
//               i_pop               dequeue head (ignored when empty)
//               o_head              current head entry
//               o_full, o_empty     occupancy flags
// Revision    : 1.0  initial release
// ============================================================================
module mem_queue
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire   clk,
  input  wire   rst,
  input  wire   i_push,
  input  MemReq i_push_data,
  input  wire   i_pop,
  output MemReq o_head,
  output logic  o_full,
  output logic  o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

  MemReq            r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PTR_W + 1)'(1);
      end
    end
  end

  assign o_head  = r_buf[r_rd_ptr];
  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module      : main_memory
// Description : Fixed-latency word memory. Requests are accepted every cycle
//               into an in-order queue; a single engine executes one op at a
//               time, completing it LATENCY cycles after it entered. The
//               engine spends the completion cycle BUSY and only picks up
//               the next op from IDLE one cycle later.
// Ports       : clk       clock
//               rst       synchronous active-high reset
//               rx_bp     MemBus slave (requests in, read responses out)
//               overflow  sticky: a request was dropped on a full queue
// Revision    : 1.0  initial release
// ============================================================================
module main_memory
  import cache_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  wire        clk,
  input  wire        rst,
  MemBus.slave       rx_bp,
  output logic       overflow
);

  localparam int MEM_WORDS = 2 ** ADDR_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Loaded on entry; the op completes on the edge where the count is 1,
  // and count 0 marks the completion cycle itself.
  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  logic [0:0] r_state;
  logic [3:0] r_cnt;
  MemReq      r_eng;
  UbitData    r_mem [MEM_WORDS];
  logic       r_rsp_vld;
  UbitData    r_rsp_data;
  logic       r_overflow;

  MemReq w_in_req;
  MemReq w_q_head;
  logic  w_q_full;
  logic  w_q_empty;
  logic  w_req_vld;
  logic  w_idle;
  logic  w_pop;
  logic  w_bypass;
  logic  w_push;
  logic  w_drop;

  always_comb begin
    w_in_req      = '0;
    w_in_req.op   = rx_bp.req_op;
    w_in_req.addr = rx_bp.req_addr;
    w_in_req.data = rx_bp.req_data;
  end

  assign w_req_vld = (rx_bp.req_op != Op_INVALID);
  assign w_idle    = (r_state == S_IDLE);
  // Queued work always goes first so completion order equals arrival order.
  assign w_pop     = w_idle && !w_q_empty;
  assign w_bypass  = w_idle && w_q_empty && w_req_vld;
  assign w_push    = w_req_vld && !w_bypass;
  assign w_drop    = w_push && w_q_full && !w_pop;

  mem_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_in_req),
    .i_pop       (w_pop),
    .o_head      (w_q_head),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_eng      <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rsp_vld <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_pop) begin
          r_eng   <= w_q_head;
          r_cnt   <= C_CNT_LOAD;
          r_state <= S_BUSY;
        end else if (w_bypass) begin
          r_eng   <= w_in_req;
          r_cnt   <= C_CNT_LOAD;
          r_state <= S_BUSY;
        end
      end else begin
        if (r_cnt == 4'd1) begin
          r_cnt <= '0;
          if (r_eng.op == Op_READ) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_data <= r_mem[r_eng.addr];
          end else if (r_eng.op == Op_WRITE) begin
            r_mem[r_eng.addr] <= r_eng.data;
          end
        end else if (r_cnt == 4'd0) begin
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign rx_bp.rsp_vld  = r_rsp_vld;
  assign rx_bp.rsp_data = r_rsp_data;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory
// Description : Self-checking bench for main_memory. A transaction-level
//               reference (pending-op queue, one in-flight op with its
//               completion cycle, array memory) predicts every output each
//               cycle; directed scenarios are followed by random traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_main_memory;
  import cache_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf;

  MemBus bus ();

  main_memory #(
    .LATENCY     (LAT),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_bp    (bus),
    .overflow (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int      cyc;
  MemReq   pend_q[$];
  bit      m_busy;
  MemReq   m_req;
  int      m_done;
  int      m_free;
  UbitData ref_mem [2**ADDR_WIDTH];
  logic    exp_vld;
  UbitData exp_data;
  logic    exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_busy   = 1'b0;
    m_req    = '0;
    m_done   = 0;
    m_free   = 0;
    exp_vld  = 1'b0;
    exp_data = '0;
    exp_ovf  = 1'b0;
    for (int i = 0; i < 2**ADDR_WIDTH; i++) ref_mem[i] = '0;
  endtask

  // One bus cycle: drive inputs, predict and check this cycle's outputs,
  // then advance the reference with this cycle's inputs.
  task automatic do_cycle(input bit r, input Op op, input UbitAddr a, input UbitData d);
    MemReq req;
    bit    bypassed;
    @(posedge clk);
    #1;
    rst          = r;
    bus.req_op   = op;
    bus.req_addr = a;
    bus.req_data = d;

    exp_vld = 1'b0;
    if (m_busy && m_done == cyc) begin
      if (m_req.op == Op_READ) begin
        exp_vld  = 1'b1;
        exp_data = ref_mem[m_req.addr];
      end else begin
        ref_mem[m_req.addr] = m_req.data;
      end
      m_busy = 1'b0;
    end

    @(negedge clk);
    check("rsp_vld", 32'(bus.rsp_vld), 32'(exp_vld));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    check("overflow", 32'(ovf), 32'(exp_ovf));

    if (r) begin
      model_reset();
    end else begin
      req.op   = op;
      req.addr = a;
      req.data = d;
      bypassed = 1'b0;
      if (!m_busy && cyc >= m_free) begin
        if (pend_q.size() > 0) begin
          m_req  = pend_q.pop_front();
          m_busy = 1'b1;
        end else if (op != Op_INVALID) begin
          m_req    = req;
          m_busy   = 1'b1;
          bypassed = 1'b1;
        end
        if (m_busy) begin
          m_done = cyc + LAT;
          m_free = cyc + LAT + 1;
        end
      end
      if (op != Op_INVALID && !bypassed) begin
        if (pend_q.size() < DEPTH) pend_q.push_back(req);
        else exp_ovf = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, Op_INVALID, '0, '0);
  endtask

  task automatic rd(input UbitAddr a);
    do_cycle(1'b0, Op_READ, a, UbitData'($urandom));
  endtask

  task automatic wr(input UbitAddr a, input UbitData d);
    do_cycle(1'b0, Op_WRITE, a, d);
  endtask

  task automatic reset_cycle();
    do_cycle(1'b1, Op_INVALID, '0, '0);
  endtask

  initial begin
    int sel;
    bus.req_op   = Op_INVALID;
    bus.req_addr = '0;
    bus.req_data = '0;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset state, then a single read of a cleared location
    idle(3);
    rd(8'h05);
    idle(6);

    // Write then read of the same word: read waits for the write
    wr(8'h05, 8'hAB);
    rd(8'h05);
    idle(11);

    // Write/read pair to different words, then read back the written word
    wr(8'h07, 8'h11);
    rd(8'h03);
    idle(11);
    rd(8'h07);
    idle(6);

    // Six back-to-back reads: queue full with a pop in the same cycle
    reset_cycle();
    for (int i = 0; i < 6; i++) rd(UbitAddr'(i));
    idle(40);
    check("ovf_full_with_pop", 32'(ovf), 32'd0);

    // Eight back-to-back reads: last two dropped, overflow sticks
    for (int i = 0; i < 8; i++) rd(UbitAddr'(i));
    idle(40);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Reset aborts an in-flight read
    reset_cycle();
    rd(8'h05);
    idle(1);
    reset_cycle();
    idle(6);
    rd(8'h05);
    idle(6);

    // Top address is its own location
    wr(8'hFF, 8'h5A);
    wr(8'h00, 8'hC3);
    rd(8'hFF);
    rd(8'h00);
    idle(25);

    // Random traffic over a small address window with rare resets
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel == 0) begin
        reset_cycle();
      end else if (sel < 60) begin
        idle(1);
      end else if (sel < 80) begin
        rd(UbitAddr'($urandom_range(0, 15)));
      end else if (sel < 98) begin
        wr(UbitAddr'($urandom_range(0, 15)), UbitData'($urandom));
      end else begin
        rd(UbitAddr'($urandom));
      end
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
